// File: rtl/id_decode_queue_if.sv
// Handshake bundle between fetch, the decode queue and the microcode sequencer.
// The slave modport faces the decode queue; master faces the surrounding stages.
interface id_decode_queue_if #(
  parameter int ADDR_W = 5
);
  logic [31:0]       in_inst;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_decode_addr;
  logic [4:0]        out_rs1_idx;
  logic [4:0]        out_rs2_idx;
  logic [4:0]        out_rd_idx;
  logic [2:0]        out_funct3;
  logic [31:0]       out_imm;
  logic              out_cond_branch;
  logic              out_uncond_branch;
  logic              out_illegal;

  modport slave (
    input  in_inst, in_valid, out_ready,
    output in_ready, out_valid, out_decode_addr, out_rs1_idx, out_rs2_idx,
           out_rd_idx, out_funct3, out_imm, out_cond_branch, out_uncond_branch,
           out_illegal
  );

  modport master (
    output in_inst, in_valid, out_ready,
    input  in_ready, out_valid, out_decode_addr, out_rs1_idx, out_rs2_idx,
           out_rd_idx, out_funct3, out_imm, out_cond_branch, out_uncond_branch,
           out_illegal
  );
endinterface

// File: rtl/id_decode_queue.sv
// RV32 decode stage feeding a DEPTH-entry micro-op queue; decode is combinational
// on the fetched word and captured at the tail, the head drives the sequencer.
module id_decode_queue #(
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 5,
  parameter bit DROP_ILLEGAL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  id_decode_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              illegal_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [31:0]       imm;
    logic              cond;
    logic              uncond;
    logic              illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            accept;
  logic            push;
  logic            pop;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  uaddr;
  logic        legal;
  logic        writes_rd;
  logic        is_branch;
  logic        is_jump;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  always_comb begin
    uaddr     = 5'd18;
    legal     = 1'b0;
    writes_rd = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        writes_rd = 1'b1;
        if (f7 == 7'h00) begin
          legal = 1'b1;
          case (f3)
            3'd0:    uaddr = 5'd4;
            3'd4:    uaddr = 5'd6;
            3'd6:    uaddr = 5'd7;
            3'd7:    uaddr = 5'd5;
            default: legal = 1'b0;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          legal = 1'b1;
          uaddr = 5'd3;
        end
      end
      7'b0010011: begin
        writes_rd = 1'b1;
        legal     = 1'b1;
        case (f3)
          3'd0:    uaddr = 5'd8;
          3'd7:    uaddr = 5'd9;
          3'd4:    uaddr = 5'd10;
          3'd6:    uaddr = 5'd11;
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin writes_rd = 1'b1; legal = (f3 == 3'd2); uaddr = 5'd0; end
      7'b0100011: begin legal = (f3 == 3'd2); uaddr = 5'd2; end
      7'b0110111: begin writes_rd = 1'b1; legal = 1'b1; uaddr = 5'd12; end
      7'b0010111: begin writes_rd = 1'b1; legal = 1'b1; uaddr = 5'd13; end
      7'b1101111: begin writes_rd = 1'b1; is_jump = 1'b1; legal = 1'b1; uaddr = 5'd14; end
      7'b1100111: begin writes_rd = 1'b1; is_jump = 1'b1; legal = (f3 == 3'd0); uaddr = 5'd16; end
      7'b1100011: begin
        is_branch = 1'b1;
        legal     = (f3 != 3'd2) && (f3 != 3'd3);
        uaddr     = (f3[2:1] == 2'b10) ? 5'd20 : (f3[2:1] == 2'b11) ? 5'd21 : 5'd19;
      end
      7'b1110011: begin legal = (inst[31:20] == 12'd1); uaddr = 5'd18; end
      default: ;
    endcase

    dec         = '0;
    dec.addr    = legal ? ADDR_W'(uaddr) : ADDR_W'(18);
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.rd      = (legal && writes_rd) ? inst[11:7] : 5'd0;
    dec.funct3  = f3;
    dec.cond    = legal && is_branch;
    dec.uncond  = legal && is_jump;
    dec.illegal = !legal;
    case (opcode)
      7'b0100011:             dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'b1100011:             dec.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      7'b1101111:             dec.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      7'b0110111, 7'b0010111: dec.imm = {inst[31:12], 12'd0};
      default:                dec.imm = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

  assign bus.in_ready  = (count < CW'(DEPTH));
  assign bus.out_valid = (count != '0);

  // Accepted-but-dropped illegals still complete the input handshake.
  assign accept = bus.in_valid && bus.in_ready && !flush;
  assign push   = accept && !(DROP_ILLEGAL && dec.illegal);
  assign pop    = bus.out_valid && bus.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      illegal_cnt <= '0;
    end else begin
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
      if (accept && dec.illegal && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign head                  = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.out_decode_addr   = head.addr;
  assign bus.out_rs1_idx       = head.rs1;
  assign bus.out_rs2_idx       = head.rs2;
  assign bus.out_rd_idx        = head.rd;
  assign bus.out_funct3        = head.funct3;
  assign bus.out_imm           = head.imm;
  assign bus.out_cond_branch   = head.cond;
  assign bus.out_uncond_branch = head.uncond;
  assign bus.out_illegal       = head.illegal;
endmodule
